// File: rtl/sprite_rom_arbiter.sv
// Shares one single-port sprite ROM between the P1 and P2 fetch paths using round-robin arbitration.
// Define SPRITE_ARB_STATS_EN to build the per-frame conflict counter; otherwise conflict_count is tied to 0.
module sprite_rom_arbiter #(
    parameter int ADDR_W      = 12,
    parameter int DATA_W      = 24,
    parameter int ROM_LATENCY = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              p1_req_valid,
    input  logic [ADDR_W-1:0] p1_req_addr,
    output logic              p1_req_ready,
    output logic              p1_rsp_valid,
    output logic [DATA_W-1:0] p1_rsp_data,
    input  logic              p2_req_valid,
    input  logic [ADDR_W-1:0] p2_req_addr,
    output logic              p2_req_ready,
    output logic              p2_rsp_valid,
    output logic [DATA_W-1:0] p2_rsp_data,
    output logic              rom_en,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [DATA_W-1:0] rom_data,
    input  logic              frame_start,
    output logic [15:0]       conflict_count
);

    typedef enum logic {OWNER_P1 = 1'b0, OWNER_P2 = 1'b1} owner_e;

    owner_e              lastGrant_q, lastGrant_d;
    logic                p1Grant, p2Grant, anyGrant;
    logic                romEn_q;
    logic [ADDR_W-1:0]   romAddr_q, romAddr_d;
    logic [ROM_LATENCY:0] tagValid_q, tagValid_d;
    logic [ROM_LATENCY:0] tagOwner_q, tagOwner_d;
    logic                p1RspValid_q, p2RspValid_q;
    logic [DATA_W-1:0]   p1RspData_q, p2RspData_q;
    logic                p1RspValid_d, p2RspValid_d;

    // On a conflict the requester that did not win last time gets the ROM.
    always_comb begin
        p1Grant     = 1'b0;
        p2Grant     = 1'b0;
        if (!reset) begin
            if (p1_req_valid && p2_req_valid) begin
                p1Grant = (lastGrant_q == OWNER_P2);
                p2Grant = (lastGrant_q == OWNER_P1);
            end else begin
                p1Grant = p1_req_valid;
                p2Grant = p2_req_valid;
            end
        end
        anyGrant    = p1Grant | p2Grant;

        lastGrant_d = lastGrant_q;
        if (p1Grant) begin
            lastGrant_d = OWNER_P1;
        end else if (p2Grant) begin
            lastGrant_d = OWNER_P2;
        end

        romAddr_d = romAddr_q;
        if (p2Grant) begin
            romAddr_d = p2_req_addr;
        end else if (p1Grant) begin
            romAddr_d = p1_req_addr;
        end

        // Tag bit 1 marks a P2 access; the last stage lines up with rom_data.
        tagValid_d   = {tagValid_q[ROM_LATENCY-1:0], anyGrant};
        tagOwner_d   = {tagOwner_q[ROM_LATENCY-1:0], p2Grant};
        p1RspValid_d = tagValid_q[ROM_LATENCY] && !tagOwner_q[ROM_LATENCY];
        p2RspValid_d = tagValid_q[ROM_LATENCY] &&  tagOwner_q[ROM_LATENCY];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            lastGrant_q  <= OWNER_P2;
            romEn_q      <= 1'b0;
            romAddr_q    <= '0;
            tagValid_q   <= '0;
            tagOwner_q   <= '0;
            p1RspValid_q <= 1'b0;
            p2RspValid_q <= 1'b0;
            p1RspData_q  <= '0;
            p2RspData_q  <= '0;
        end else begin
            lastGrant_q  <= lastGrant_d;
            romEn_q      <= anyGrant;
            romAddr_q    <= romAddr_d;
            tagValid_q   <= tagValid_d;
            tagOwner_q   <= tagOwner_d;
            p1RspValid_q <= p1RspValid_d;
            p2RspValid_q <= p2RspValid_d;
            if (p1RspValid_d) begin
                p1RspData_q <= rom_data;
            end
            if (p2RspValid_d) begin
                p2RspData_q <= rom_data;
            end
        end
    end

    assign p1_req_ready = p1Grant;
    assign p2_req_ready = p2Grant;
    assign rom_en       = romEn_q;
    assign rom_addr     = romAddr_q;
    assign p1_rsp_valid = p1RspValid_q;
    assign p2_rsp_valid = p2RspValid_q;
    assign p1_rsp_data  = p1RspData_q;
    assign p2_rsp_data  = p2RspData_q;

`ifdef SPRITE_ARB_STATS_EN
    logic [15:0] conflictCount_q, conflictCount_d;
    logic        conflict;

    // A frame_start that coincides with a conflict restarts the count at 1.
    always_comb begin
        conflict        = p1_req_valid && p2_req_valid;
        conflictCount_d = conflictCount_q;
        if (frame_start) begin
            conflictCount_d = {15'd0, conflict};
        end else if (conflict && (conflictCount_q != 16'hFFFF)) begin
            conflictCount_d = conflictCount_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            conflictCount_q <= '0;
        end else begin
            conflictCount_q <= conflictCount_d;
        end
    end

    assign conflict_count = conflictCount_q;
`else
    logic unusedFrameStart;
    assign unusedFrameStart = frame_start;
    assign conflict_count   = 16'd0;
`endif

endmodule

// File: tb/tb_sprite_rom_arbiter.sv
// Self-checking bench for sprite_rom_arbiter: directed scenarios plus randomized traffic against
// a transaction-level model (expected grants, response queue with due cycles, conflict counter).
module tb_sprite_rom_arbiter;

    localparam int AW  = 12;
    localparam int DW  = 24;
    localparam int LAT = 2;
`ifdef SPRITE_ARB_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          p1_req_valid = 1'b0, p2_req_valid = 1'b0;
    logic [AW-1:0] p1_req_addr = '0, p2_req_addr = '0;
    logic          p1_req_ready, p2_req_ready;
    logic          p1_rsp_valid, p2_rsp_valid;
    logic [DW-1:0] p1_rsp_data, p2_rsp_data;
    logic          rom_en;
    logic [AW-1:0] rom_addr;
    logic [DW-1:0] romData;
    logic          frame_start = 1'b0;
    logic [15:0]   conflict_count;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    sprite_rom_arbiter #(.ADDR_W(AW), .DATA_W(DW), .ROM_LATENCY(LAT)) dut (
        .clk(clk), .reset(reset),
        .p1_req_valid(p1_req_valid), .p1_req_addr(p1_req_addr), .p1_req_ready(p1_req_ready),
        .p1_rsp_valid(p1_rsp_valid), .p1_rsp_data(p1_rsp_data),
        .p2_req_valid(p2_req_valid), .p2_req_addr(p2_req_addr), .p2_req_ready(p2_req_ready),
        .p2_rsp_valid(p2_rsp_valid), .p2_rsp_data(p2_rsp_data),
        .rom_en(rom_en), .rom_addr(rom_addr), .rom_data(romData),
        .frame_start(frame_start), .conflict_count(conflict_count)
    );

    function automatic logic [DW-1:0] romWord(input logic [AW-1:0] a);
        if (a == 12'h010) return 24'hA0B0C0;
        return 24'(a * 24'd40503 + 24'h13579B);
    endfunction

    // Synchronous ROM: address sampled at an edge appears LAT cycles later.
    logic [AW-1:0] romPipe [LAT];
    always @(posedge clk) begin
        romPipe[0] <= rom_addr;
        for (int i = 1; i < LAT; i++) romPipe[i] <= romPipe[i-1];
    end
    assign romData = romWord(romPipe[LAT-1]);

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void grantOf(input bit v1, input bit v2, input bit lastP2,
                                    output bit g1, output bit g2);
        g1 = v1 && (!v2 || lastP2);
        g2 = v2 && (!v1 || !lastP2);
    endfunction

    typedef struct {
        int            due;
        bit            owner;
        logic [AW-1:0] addr;
    } rsp_t;

    rsp_t          pending[$];
    bit            mLastP2 = 1'b1;
    bit            mRomEn = 1'b0;
    logic [AW-1:0] mRomAddr = '0;
    logic [DW-1:0] mP1Data = '0, mP2Data = '0;
    int            mCount = 0;
    int            cyc = 0;
    bit            modelLive = 1'b0;

    // Model: each accepted request is owed a response LAT+2 cycles after its handshake cycle.
    always @(posedge clk) begin
        bit g1, g2, conflict;
        if (reset) begin
            pending.delete();
            mLastP2   = 1'b1;
            mRomEn    = 1'b0;
            mRomAddr  = '0;
            mP1Data   = '0;
            mP2Data   = '0;
            mCount    = 0;
            modelLive = 1'b1;
        end else begin
            grantOf(p1_req_valid, p2_req_valid, mLastP2, g1, g2);
            mRomEn = g1 | g2;
            if (g1) begin
                pending.push_back('{cyc + LAT + 2, 1'b0, p1_req_addr});
                mRomAddr = p1_req_addr;
                mLastP2  = 1'b0;
            end else if (g2) begin
                pending.push_back('{cyc + LAT + 2, 1'b1, p2_req_addr});
                mRomAddr = p2_req_addr;
                mLastP2  = 1'b1;
            end
            conflict = p1_req_valid && p2_req_valid;
            if (frame_start) mCount = conflict ? 1 : 0;
            else if (conflict && mCount < 32'hFFFF) mCount = mCount + 1;
        end
        cyc = cyc + 1;
    end

    always @(negedge clk) begin
        bit   g1, g2, e1, e2;
        rsp_t r;
        if (modelLive) begin
            grantOf(p1_req_valid, p2_req_valid, mLastP2, g1, g2);
            if (reset) begin
                g1 = 1'b0;
                g2 = 1'b0;
            end
            e1 = 1'b0;
            e2 = 1'b0;
            if (pending.size() > 0 && pending[0].due == cyc) begin
                r = pending.pop_front();
                if (r.owner) begin
                    e2      = 1'b1;
                    mP2Data = romWord(r.addr);
                end else begin
                    e1      = 1'b1;
                    mP1Data = romWord(r.addr);
                end
            end
            checkOutput("p1Ready", p1_req_ready, g1);
            checkOutput("p2Ready", p2_req_ready, g2);
            checkOutput("romEn", rom_en, mRomEn);
            checkOutput("romAddr", rom_addr, mRomAddr);
            checkOutput("p1RspValid", p1_rsp_valid, e1);
            checkOutput("p2RspValid", p2_rsp_valid, e2);
            checkOutput("p1RspData", p1_rsp_data, mP1Data);
            checkOutput("p2RspData", p2_rsp_data, mP2Data);
            checkOutput("conflictCount", conflict_count, STATS ? mCount : 0);
        end
    end

    // Drives one cycle of requests; reports which requests were accepted in that cycle.
    task automatic applyStimulus(input bit v1, input logic [AW-1:0] a1, input bit v2,
                                 input logic [AW-1:0] a2, input bit fs, output bit f1, output bit f2);
        p1_req_valid = v1;
        p1_req_addr  = a1;
        p2_req_valid = v2;
        p2_req_addr  = a2;
        frame_start  = fs;
        @(negedge clk);
        f1 = p1_req_valid && p1_req_ready;
        f2 = p2_req_valid && p2_req_ready;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        bit f1, f2;
        for (int i = 0; i < n; i++) applyStimulus(1'b0, '0, 1'b0, '0, 1'b0, f1, f2);
    endtask

    task automatic resetFor(input int n);
        reset = 1'b1;
        idle(n);
        reset = 1'b0;
    endtask

    initial begin
        bit            f1, f2, v1, v2, fs;
        logic [AW-1:0] a1, a2;
        logic [AW-1:0] expSeq [4];
        int            expOwner [4];
        int            i1, i2, cnt, own;

        @(posedge clk);
        #1;
        resetFor(2);
        idle(2);

        // Single P1 fetch of the pinned word.
        applyStimulus(1'b1, 12'h010, 1'b0, '0, 1'b0, f1, f2);
        checkOutput("singleAccept", f1, 1);
        checkOutput("singleRomEn", rom_en, 1);
        checkOutput("singleRomAddr", rom_addr, 12'h010);
        idle(3);
        checkOutput("singleRspValid", p1_rsp_valid, 1);
        checkOutput("singleRspData", p1_rsp_data, 24'hA0B0C0);
        checkOutput("singleP2Quiet", p2_rsp_valid, 0);
        idle(1);
        checkOutput("singleRspPulse", p1_rsp_valid, 0);
        checkOutput("singleRspHold", p1_rsp_data, 24'hA0B0C0);

        // Continuous conflict straight out of reset alternates starting with P1.
        resetFor(2);
        expSeq   = '{12'h100, 12'h200, 12'h101, 12'h201};
        expOwner = '{1, 2, 1, 2};
        i1 = 0;
        i2 = 0;
        for (int k = 0; k < 4; k++) begin
            applyStimulus(1'b1, 12'(12'h100 + i1), 1'b1, 12'(12'h200 + i2), 1'b0, f1, f2);
            if (f1) i1++;
            if (f2) i2++;
            checkOutput("conflictRomAddr", rom_addr, expSeq[k]);
        end
        for (int k = 0; k < 4; k++) begin
            own = p1_rsp_valid ? 1 : (p2_rsp_valid ? 2 : 0);
            checkOutput("conflictRspOwner", own, expOwner[k]);
            idle(1);
        end

        // P2 streaming alone: accepted every cycle, eight back-to-back responses.
        resetFor(1);
        cnt = 0;
        for (int k = 0; k < 14; k++) begin
            if (k < 8) begin
                applyStimulus(1'b0, '0, 1'b1, 12'(12'h300 + k), 1'b0, f1, f2);
                checkOutput("streamReady", f2, 1);
            end else begin
                idle(1);
            end
            if (p2_rsp_valid) cnt++;
        end
        checkOutput("streamRspCount", cnt, 8);

        // Reset with three P1 fetches in flight: none may respond.
        resetFor(1);
        idle(1);
        for (int k = 0; k < 3; k++) begin
            applyStimulus(1'b1, 12'(12'h400 + k), 1'b0, '0, 1'b0, f1, f2);
            checkOutput("flightAccept", f1, 1);
        end
        cnt = p1_rsp_valid ? 1 : 0;
        reset = 1'b1;
        for (int k = 0; k < 2; k++) begin
            applyStimulus(1'b1, 12'h403, 1'b0, '0, 1'b0, f1, f2);
            checkOutput("resetReadyLow", f1, 0);
            if (p1_rsp_valid) cnt++;
        end
        reset = 1'b0;
        for (int k = 0; k < 8; k++) begin
            idle(1);
            if (p1_rsp_valid) cnt++;
        end
        checkOutput("resetDropped", cnt, 0);
        applyStimulus(1'b1, 12'h500, 1'b1, 12'h600, 1'b0, f1, f2);
        checkOutput("postResetP1Wins", f1, 1);
        checkOutput("postResetP2Waits", f2, 0);
        idle(6);

        // Conflict statistics.
        resetFor(1);
        i1 = 0;
        i2 = 0;
        for (int k = 0; k < 5; k++) begin
            applyStimulus(1'b1, 12'(12'h700 + i1), 1'b1, 12'(12'h800 + i2), 1'b0, f1, f2);
            if (f1) i1++;
            if (f2) i2++;
        end
        checkOutput("stats5", conflict_count, STATS ? 5 : 0);
        applyStimulus(1'b0, '0, 1'b0, '0, 1'b1, f1, f2);
        checkOutput("statsCleared", conflict_count, 0);
        for (int k = 0; k < 3; k++) begin
            applyStimulus(1'b1, 12'(12'h700 + i1), 1'b1, 12'(12'h800 + i2), 1'b0, f1, f2);
            if (f1) i1++;
            if (f2) i2++;
        end
        checkOutput("stats3", conflict_count, STATS ? 3 : 0);
        applyStimulus(1'b1, 12'(12'h700 + i1), 1'b1, 12'(12'h800 + i2), 1'b1, f1, f2);
        if (f1) i1++;
        if (f2) i2++;
        checkOutput("statsCoincident", conflict_count, STATS ? 1 : 0);
        for (int k = 0; k < 70000; k++) begin
            applyStimulus(1'b1, 12'(12'h700 + i1), 1'b1, 12'(12'h800 + i2), 1'b0, f1, f2);
            if (f1) i1++;
            if (f2) i2++;
        end
        checkOutput("statsSaturate", conflict_count, STATS ? 16'hFFFF : 0);
        idle(6);

        // Random traffic; requesters hold a pending request except for an occasional drop.
        v1 = 1'b0;
        v2 = 1'b0;
        a1 = '0;
        a2 = '0;
        f1 = 1'b0;
        f2 = 1'b0;
        for (int n = 0; n < 3000; n++) begin
            if (!(v1 && !f1) || $urandom_range(15) == 0) begin
                v1 = ($urandom_range(2) != 0);
                a1 = AW'($urandom);
            end
            if (!(v2 && !f2) || $urandom_range(15) == 0) begin
                v2 = ($urandom_range(2) != 0);
                a2 = AW'($urandom);
            end
            reset = ($urandom_range(299) == 0);
            fs    = ($urandom_range(40) == 0);
            applyStimulus(v1, a1, v2, a2, fs, f1, f2);
        end
        reset = 1'b0;
        idle(10);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
